// File: rtl/tdes_pkg.sv
// Shared Triple-DES sequencer definitions: FSM states, mode and key-set codes,
// IP/FP bit tables (1-based, bit 1 = MSB) and the lookup helper used by tdes_perm.
package tdes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tdes_state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [1:0] KSET_K1 = 2'd0;
  localparam logic [1:0] KSET_K2 = 2'd1;
  localparam logic [1:0] KSET_K3 = 2'd2;

  localparam int ROUNDS_PER_STAGE = 16;

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  // Source bit (1-based) feeding output bit pos+1 of IP (inverse=0) or FP (inverse=1).
  function automatic int des_perm_src(input bit inverse, input int pos);
    return inverse ? FP_TAB[pos] : IP_TAB[pos];
  endfunction

endpackage

// File: rtl/tdes_perm.sv
// Pure-wiring DES initial permutation (INVERSE=0) or final permutation (INVERSE=1).
module tdes_perm
  import tdes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic [63:0] din,
  output logic [63:0] dout
);

  for (genvar i = 0; i < 64; i++) begin : g_bit
    localparam int SRC = des_perm_src(INVERSE, i);
    assign dout[63-i] = din[64-SRC];
  end

endmodule

// File: rtl/tdes_round_ctrl.sv
// Iterative single/triple DES round sequencer around an external round function.
// Optional build macro TDES_ABORT_EN adds an abort input that drops the block in flight.
module tdes_round_ctrl
  import tdes_pkg::*;
#(
  parameter int NUM_STAGES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef TDES_ABORT_EN
  input  logic        abort,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [31:0] f_r,
  output logic [1:0]  f_key_set,
  output logic [3:0]  f_key_idx,
  input  logic [31:0] f_in,
  output logic        busy
);

  if (NUM_STAGES != 1 && NUM_STAGES != 3) begin : g_bad_stages
    $error("tdes_round_ctrl: NUM_STAGES must be 1 or 3");
  end

  localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);

  tdes_state_e state;
  logic [1:0]  stage;
  logic [3:0]  round;
  logic        mode;
  logic [31:0] l_q;
  logic [31:0] r_q;
  logic [63:0] ip_data;
  logic [63:0] fp_data;
  logic        abort_req;
  logic        stage_dec;

  tdes_perm #(.INVERSE(1'b0)) u_ip (.din(in_data),    .dout(ip_data));
  tdes_perm #(.INVERSE(1'b1)) u_fp (.din({l_q, r_q}), .dout(fp_data));

`ifdef TDES_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Middle stage of a 3-stage block runs opposite to the block mode (EDE / DED).
  assign stage_dec = mode ^ (stage == 2'd1);

  always_comb begin
    f_key_set = KSET_K1;
    f_key_idx = '0;
    f_r       = '0;
    if (state == ST_RUN) begin
      f_key_set = (mode == MODE_DEC) ? (LAST_STAGE - stage) : stage;
      f_key_idx = stage_dec ? (4'd15 - round) : round;
      f_r       = r_q;
    end
  end

  assign in_ready = rst_n && (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign out_data = out_valid ? fp_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      stage     <= '0;
      round     <= '0;
      mode      <= MODE_ENC;
      l_q       <= '0;
      r_q       <= '0;
      out_valid <= 1'b0;
    end else if (abort_req && state != ST_IDLE) begin
      state     <= ST_IDLE;
      stage     <= '0;
      round     <= '0;
      l_q       <= '0;
      r_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            {l_q, r_q} <= ip_data;
            mode       <= in_mode;
            stage      <= '0;
            round      <= '0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Last round skips the swap, which is FP of this stage followed by IP of the next.
          if (round == 4'(ROUNDS_PER_STAGE - 1)) begin
            l_q   <= l_q ^ f_in;
            round <= '0;
            if (stage == LAST_STAGE) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end else begin
              stage <= stage + 2'd1;
            end
          end else begin
            l_q   <= r_q;
            r_q   <= l_q ^ f_in;
            round <= round + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdes_round_ctrl.sv
// Directed bench for tdes_round_ctrl (NUM_STAGES=3) with a behavioural DES round function and key store.
module tb_tdes_round_ctrl;

  localparam logic M_ENC = 1'b0;
  localparam logic M_DEC = 1'b1;

  localparam int E_TAB [48] = '{
    32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,  24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32, 1
  };
  localparam int P_TAB [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
  };
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
  };
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SB [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11
  };

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [31:0] f_r;
  logic [1:0]  f_key_set;
  logic [3:0]  f_key_idx;
  logic [31:0] f_in;
  logic        busy;
`ifdef TDES_ABORT_EN
  logic        abort;
`endif

  logic [47:0] subkeys [4][16];
  logic [1:0]  ks_log [48];
  logic [3:0]  ki_log [48];
  int n_tests = 0;
  int n_fail  = 0;

  tdes_round_ctrl #(.NUM_STAGES(3)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef TDES_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .f_r(f_r), .f_key_set(f_key_set), .f_key_idx(f_key_idx), .f_in(f_in), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  b;
    int row, col;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_TAB[i]];
    e = e ^ k;
    for (int n = 0; n < 8; n++) begin
      b   = e[47-6*n -: 6];
      row = {30'd0, b[5], b[0]};
      col = {28'd0, b[4:1]};
      s[31-4*n -: 4] = 4'(SB[n*64 + row*16 + col]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TAB[i]];
    return p;
  endfunction

  always_comb f_in = des_f(f_r, subkeys[f_key_set][f_key_idx]);

  task automatic load_key(input int set, input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_TAB[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) subkeys[set][r][47-i] = cd[56-PC2_TAB[i]];
    end
  endtask

  function automatic logic [1:0] exp_set(input logic m, input int n);
    int s = n / 16;
    return m ? 2'(2 - s) : 2'(s);
  endfunction

  function automatic logic [3:0] exp_idx(input logic m, input int n);
    int s = n / 16;
    int r = n % 16;
    logic dec = m ^ (s == 1);
    return dec ? 4'(15 - r) : 4'(r);
  endfunction

  // Offer one block from IDLE and wait (bounded) for out_valid, logging the key selects per round.
  task automatic start_block(input logic m, input logic [63:0] d, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 64'h0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (lat < 48) begin
        ks_log[lat] = f_key_set;
        ki_log[lat] = f_key_idx;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b busy=%b out_data=%h, required 0 0 0 0",
               in_ready, out_valid, busy, out_data);
    end
    n_tests++;
    if (f_key_set !== 2'd0 || f_key_idx !== 4'd0 || f_r !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_round_if: set=%0d idx=%0d f_r=%h, required 0 0 0", f_key_set, f_key_idx, f_r);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_encrypt_same_keys();
    int lat, bad;
    for (int s = 0; s < 3; s++) load_key(s, 64'h133457799BBCDFF1);
    start_block(M_ENC, 64'h0123456789ABCDEF, lat);
    n_tests++;
    if (lat !== 48) begin
      n_fail++;
      $display("FAIL enc_latency: got %0d edges, required 48", lat);
    end
    n_tests++;
    if (out_data !== 64'h85E813540F0AB405) begin
      n_fail++;
      $display("FAIL enc_result: got %h, required 85e813540f0ab405", out_data);
    end
    bad = 0;
    for (int n = 0; n < 48; n++)
      if (ks_log[n] !== exp_set(M_ENC, n) || ki_log[n] !== exp_idx(M_ENC, n)) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL enc_key_sched: %0d bad rounds, required 0", bad);
    end
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || f_r !== 32'h0 || f_key_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL done_state: busy=%b in_ready=%b f_r=%h idx=%0d, required 1 0 0 0",
               busy, in_ready, f_r, f_key_idx);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'h0) begin
      n_fail++;
      $display("FAIL enc_handshake: in_ready=%b out_valid=%b out_data=%h, required 1 0 0",
               in_ready, out_valid, out_data);
    end
  endtask

  task automatic test_decrypt_same_keys();
    int lat, bad;
    start_block(M_DEC, 64'h85E813540F0AB405, lat);
    n_tests++;
    if (lat !== 48 || out_data !== 64'h0123456789ABCDEF) begin
      n_fail++;
      $display("FAIL dec_result: got %h after %0d edges, required 0123456789abcdef after 48", out_data, lat);
    end
    bad = 0;
    for (int n = 0; n < 48; n++)
      if (ks_log[n] !== exp_set(M_DEC, n) || ki_log[n] !== exp_idx(M_DEC, n)) bad++;
    n_tests++;
    if (bad != 0 || ki_log[0] !== 4'd15 || ks_log[0] !== 2'd2 || ki_log[16] !== 4'd0) begin
      n_fail++;
      $display("FAIL dec_key_sched: %0d bad rounds, first set=%0d idx=%0d, required 0 bad, set 2 idx 15",
               bad, ks_log[0], ki_log[0]);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_distinct_keys();
    int lat, bad;
    logic [63:0] ct;
    load_key(0, 64'h0123456789ABCDEF);
    load_key(1, 64'h23456789ABCDEF01);
    load_key(2, 64'h456789ABCDEF0123);
    start_block(M_ENC, 64'h5468652071756663, lat);
    ct = out_data;
    n_tests++;
    if (lat !== 48 || ct === 64'h5468652071756663 || ct === 64'h0) begin
      n_fail++;
      $display("FAIL tdes_enc: got %h after %0d edges, required a non-trivial result after 48", ct, lat);
    end
    n_tests++;
    if (ks_log[0] !== 2'd0 || ks_log[20] !== 2'd1 || ks_log[40] !== 2'd2) begin
      n_fail++;
      $display("FAIL tdes_enc_sets: got %0d,%0d,%0d, required 0,1,2", ks_log[0], ks_log[20], ks_log[40]);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    start_block(M_DEC, ct, lat);
    n_tests++;
    if (out_data !== 64'h5468652071756663) begin
      n_fail++;
      $display("FAIL tdes_roundtrip: got %h, required 5468652071756663", out_data);
    end
    bad = 0;
    for (int n = 0; n < 48; n++)
      if (ks_log[n] !== exp_set(M_DEC, n) || ki_log[n] !== exp_idx(M_DEC, n)) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL tdes_dec_sched: %0d bad rounds, required 0", bad);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat, bad;
    logic [63:0] held;
    for (int s = 0; s < 3; s++) load_key(s, 64'h133457799BBCDFF1);
    start_block(M_ENC, 64'h0123456789ABCDEF, lat);
    held = out_data;
    in_valid = 1'b1;
    in_mode  = M_DEC;
    in_data  = 64'hFFFFFFFFFFFFFFFF;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_data !== 64'h85E813540F0AB405 || in_ready !== 1'b0 || busy !== 1'b1)
        bad++;
    end
    n_tests++;
    if (bad != 0 || held !== 64'h85E813540F0AB405) begin
      n_fail++;
      $display("FAIL stall_hold: %0d bad cycles, data %h, required 0 bad, 85e813540f0ab405", bad, out_data);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
    end
    start_block(M_DEC, 64'h85E813540F0AB405, lat);
    n_tests++;
    if (lat !== 48 || out_data !== 64'h0123456789ABCDEF) begin
      n_fail++;
      $display("FAIL stall_next_block: got %h after %0d edges, required 0123456789abcdef after 48", out_data, lat);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lat, bad;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = M_ENC;
    in_data  = 64'h0123456789ABCDEF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || f_r !== 32'h0 || f_key_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: busy=%b out_valid=%b in_ready=%b f_r=%h idx=%0d, required all 0",
               busy, out_valid, in_ready, f_r, f_key_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midrun_discard: %0d cycles with stale activity, required 0", bad);
    end
    start_block(M_ENC, 64'h0123456789ABCDEF, lat);
    n_tests++;
    if (lat !== 48 || out_data !== 64'h85E813540F0AB405) begin
      n_fail++;
      $display("FAIL midrun_fresh: got %h after %0d edges, required 85e813540f0ab405 after 48", out_data, lat);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

`ifdef TDES_ABORT_EN
  task automatic test_abort();
    int lat, bad;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = M_ENC;
    in_data  = 64'h0123456789ABCDEF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_run: busy=%b in_ready=%b out_valid=%b, required 0 1 0", busy, in_ready, out_valid);
    end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_no_valid: %0d cycles with out_valid, required 0", bad);
    end
    start_block(M_ENC, 64'h0123456789ABCDEF, lat);
    abort     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    abort     = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (lat !== 48 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_done: lat=%0d busy=%b out_valid=%b out_data=%h in_ready=%b, required 48 0 0 0 1",
               lat, busy, out_valid, out_data, in_ready);
    end
  endtask
`endif

  initial begin
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = 64'h0;
    out_ready = 1'b0;
`ifdef TDES_ABORT_EN
    abort     = 1'b0;
`endif
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 16; r++) subkeys[s][r] = 48'h0;
    test_reset();
    test_encrypt_same_keys();
    test_decrypt_same_keys();
    test_distinct_keys();
    test_backpressure();
    test_reset_mid_run();
`ifdef TDES_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
